// File: rtl/uart_recv.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling, configurable frame, one-entry valid/ready output.
// Ports: clk/rst (async active-high); frame config bps_mode/data_num/check_mode/stop_num; rx_en, uart_rxd in;
//        rx_ready in / rx_data, rx_valid, parity_err, frame_err out; overrun_err pulse; rx_busy while in a frame.
module uart_recv #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  bps_mode,
  input  logic [3:0]  data_num,
  input  logic [1:0]  check_mode,
  input  logic [1:0]  stop_num,
  input  logic        rx_en,
  input  logic        uart_rxd,
  input  logic        rx_ready,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic        overrun_err,
  output logic        rx_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int DIV0 = CLK_FREQ / 96 / 100;
  localparam int DIV1 = CLK_FREQ / 192 / 100;
  localparam int DIV2 = CLK_FREQ / 384 / 100;
  localparam int DIV3 = CLK_FREQ / 1152 / 100;
  localparam int DIV4 = CLK_FREQ / 2304 / 100;
  localparam int DIV5 = CLK_FREQ / 4608 / 100;
  localparam int DIV6 = CLK_FREQ / 9216 / 100;

  state_t      state, state_nxt;
  logic        sync1, rxd_s, rxd_d;
  logic [2:0]  bps_r;
  logic [3:0]  dn_r;
  logic [1:0]  cm_r;
  logic [1:0]  sn_r;
  logic [15:0] bps_cnt;
  logic [15:0] cnt;
  logic [15:0] word;
  logic [3:0]  bit_cnt;
  logic        perr_l, ferr_l, done;
  logic        start_go, sample, par_exp, last_data, last_stop;

  // Divisor follows the configuration captured at the start edge, not the live inputs.
  always_comb begin
    case (bps_r)
      3'd1:    bps_cnt = 16'(DIV1);
      3'd2:    bps_cnt = 16'(DIV2);
      3'd3:    bps_cnt = 16'(DIV3);
      3'd4:    bps_cnt = 16'(DIV4);
      3'd5:    bps_cnt = 16'(DIV5);
      3'd6:    bps_cnt = 16'(DIV6);
      default: bps_cnt = 16'(DIV0);
    endcase
  end

  assign start_go  = rx_en & rxd_d & ~rxd_s;
  assign sample    = (cnt == (bps_cnt >> 1));
  assign last_data = (bit_cnt == dn_r);
  assign last_stop = (bit_cnt == {2'b00, sn_r});
  assign par_exp   = (cm_r == 2'd1) ? ~^word : ^word;
  assign rx_busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_go) state_nxt = START;
      START:   if (sample) state_nxt = rxd_s ? IDLE : DATA;
      DATA:    if (sample && last_data)
                 state_nxt = (cm_r == 2'd1 || cm_r == 2'd2) ? PARITY : STOP;
      PARITY:  if (sample) state_nxt = STOP;
      STOP:    if (sample && last_stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Line synchroniser, bit timing and frame assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      rxd_s   <= 1'b1;
      rxd_d   <= 1'b1;
      bps_r   <= '0;
      dn_r    <= '0;
      cm_r    <= '0;
      sn_r    <= '0;
      cnt     <= '0;
      word    <= '0;
      bit_cnt <= '0;
      perr_l  <= 1'b0;
      ferr_l  <= 1'b0;
      done    <= 1'b0;
    end else begin
      sync1 <= uart_rxd;
      rxd_s <= sync1;
      // Edge register tracks rxd_s unconditionally, so a line held low after a
      // frame cannot retrigger until it has gone high again.
      rxd_d <= rxd_s;
      done  <= 1'b0;
      if (state == IDLE) begin
        if (start_go) begin
          bps_r   <= bps_mode;
          dn_r    <= data_num;
          cm_r    <= check_mode;
          sn_r    <= stop_num;
          cnt     <= '0;
          word    <= '0;
          bit_cnt <= '0;
          perr_l  <= 1'b0;
          ferr_l  <= 1'b0;
        end
      end else begin
        cnt <= (cnt == bps_cnt) ? 16'd0 : cnt + 16'd1;
        if (sample) begin
          case (state)
            DATA: begin
              // Shift in MSB first: the first sample ends up at bit dn_r.
              word    <= {word[14:0], rxd_s};
              bit_cnt <= last_data ? 4'd0 : bit_cnt + 4'd1;
            end
            PARITY: if (rxd_s != par_exp) perr_l <= 1'b1;
            STOP: begin
              if (!rxd_s) ferr_l <= 1'b1;
              bit_cnt <= last_stop ? 4'd0 : bit_cnt + 4'd1;
              if (last_stop) done <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Holding register; a new word may replace the held one only in the cycle it is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= done & rx_valid & ~rx_ready;
      if (done && (!rx_valid || rx_ready)) begin
        rx_data    <= word;
        parity_err <= perr_l;
        frame_err  <= ferr_l;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_recv.sv
// Testbench for uart_recv: table-driven frames, directed corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_uart_recv;
  localparam int CLK_FREQ = 50000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  bps_mode;
  logic [3:0]  data_num;
  logic [1:0]  check_mode;
  logic [1:0]  stop_num;
  logic        rx_en;
  logic        uart_rxd;
  logic        rx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        parity_err;
  logic        frame_err;
  logic        overrun_err;
  logic        rx_busy;

  uart_recv #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk(clk), .rst(rst), .bps_mode(bps_mode), .data_num(data_num),
    .check_mode(check_mode), .stop_num(stop_num), .rx_en(rx_en),
    .uart_rxd(uart_rxd), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .parity_err(parity_err), .frame_err(frame_err),
    .overrun_err(overrun_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bps; int dn; int cm; int sn; int data; int par; int stops;
    int e_data; int e_perr; int e_ferr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int q[$];
  int ov_cnt = 0;
  int busy_cnt = 0;

  // Observer: accepted words, overrun pulses and busy cycles, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid && rx_ready)
      q.push_back(int'(rx_data) | (int'(parity_err) << 16) | (int'(frame_err) << 17));
    if (overrun_err) ov_cnt++;
    if (rx_busy) busy_cnt++;
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog cycle budget expired");
    $fatal(1, "bench stopped by watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_near(input string nm, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d+-%0d", nm, act, exp, tol);
    end
  endtask

  function automatic int period(input int m);
    int r;
    case (m)
      1: r = 192;   2: r = 384;   3: r = 1152;
      4: r = 2304;  5: r = 4608;  6: r = 9216;
      default: r = 96;
    endcase
    return CLK_FREQ / r / 100 + 1;
  endfunction

  function automatic vec_t mk(input int bps, dn, cm, sn, data, par, stops, ed, ep, ef);
    vec_t v;
    v.bps = bps; v.dn = dn; v.cm = cm; v.sn = sn; v.data = data; v.par = par;
    v.stops = stops; v.e_data = ed; v.e_perr = ep; v.e_ferr = ef;
    return v;
  endfunction

  // Frame-level reference: word masked to the sent width, parity by population count,
  // frame error if any sent stop bit is low.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int w, ones, smask;
    r = v;
    w = v.data & ((1 << (v.dn + 1)) - 1);
    ones = $countones(w);
    r.e_data = w;
    r.e_perr = 0;
    if (v.cm == 2) r.e_perr = (v.par != (ones % 2)) ? 1 : 0;
    if (v.cm == 1) r.e_perr = (v.par != 1 - (ones % 2)) ? 1 : 0;
    smask = (1 << (v.sn + 1)) - 1;
    r.e_ferr = ((v.stops & smask) != smask) ? 1 : 0;
    return r;
  endfunction

  // Drives one frame; configuration is scrambled during the start bit to show it is latched.
  task automatic send_frame(input vec_t v);
    int p;
    p = period(v.bps);
    bps_mode = 3'(v.bps); data_num = 4'(v.dn); check_mode = 2'(v.cm); stop_num = 2'(v.sn);
    uart_rxd = 1'b0;
    tick(10);
    bps_mode = 3'($urandom); data_num = 4'($urandom);
    check_mode = 2'($urandom); stop_num = 2'($urandom);
    tick(p - 10);
    for (int i = v.dn; i >= 0; i--) begin
      uart_rxd = 1'((v.data >> i) & 1);
      tick(p);
    end
    if (v.cm == 1 || v.cm == 2) begin
      uart_rxd = 1'(v.par & 1);
      tick(p);
    end
    for (int i = 0; i <= v.sn; i++) begin
      uart_rxd = 1'((v.stops >> i) & 1);
      tick(p);
    end
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    int p, nbits, got, w;
    p = period(v.bps);
    q.delete();
    busy_cnt = 0;
    send_frame(v);
    w = 0;
    while (q.size() == 0 && w < 2 * p) begin tick(1); w++; end
    check({nm, "_dlv"}, q.size(), 1);
    if (q.size() > 0) begin
      got = q.pop_front();
      check({nm, "_data"}, got & 'hFFFF, v.e_data);
      check({nm, "_perr"}, (got >> 16) & 1, v.e_perr);
      check({nm, "_ferr"}, (got >> 17) & 1, v.e_ferr);
    end
    // Busy from start edge to the middle of the last stop bit, plus synchroniser lag.
    nbits = 1 + (v.dn + 1) + ((v.cm == 1 || v.cm == 2) ? 1 : 0) + v.sn;
    check_near({nm, "_busy"}, busy_cnt, nbits * p + (p - 1) / 2 + 1, 3);
    uart_rxd = 1'b1;
    tick(20);
  endtask

  vec_t tbl[9];
  vec_t v;
  int got, ov0;

  initial begin
    rst = 1'b1; rx_en = 1'b1; rx_ready = 1'b1; uart_rxd = 1'b1;
    bps_mode = 3'd6; data_num = 4'd7; check_mode = 2'd0; stop_num = 2'd0;

    tbl[0] = mk(3, 7,  0, 0, 'hA5,   0, 'hF, 'h00A5, 0, 0);
    tbl[1] = mk(6, 7,  2, 0, 'h07,   0, 'hF, 'h0007, 1, 0);
    tbl[2] = mk(6, 7,  2, 0, 'h07,   1, 'hF, 'h0007, 0, 0);
    tbl[3] = mk(6, 7,  1, 0, 'h07,   0, 'hF, 'h0007, 0, 0);
    tbl[4] = mk(6, 15, 0, 0, 'hFFFF, 0, 'hF, 'hFFFF, 0, 0);
    tbl[5] = mk(6, 3,  3, 2, 'hFA,   1, 'hF, 'h000A, 0, 0);
    tbl[6] = mk(5, 4,  1, 1, 'h13,   1, 'h2, 'h0013, 1, 1);
    tbl[7] = mk(6, 0,  2, 3, 'h1,    1, 'hF, 'h0001, 0, 0);
    tbl[8] = mk(4, 7,  0, 0, 'h3C,   0, 'h1, 'h003C, 0, 0);

    tick(3);
    check("rst_valid", int'(rx_valid), 0);
    check("rst_data", int'(rx_data), 0);
    check("rst_perr", int'(parity_err), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_ovr", int'(overrun_err), 0);
    check("rst_busy", int'(rx_busy), 0);
    rst = 1'b0;
    tick(5);

    for (int i = 0; i < 9; i++) run_frame(tbl[i], $sformatf("tbl%0d", i));

    // False start: 100-clock glitch at 115200.
    bps_mode = 3'd3; q.delete(); tick(2);
    busy_cnt = 0;
    uart_rxd = 1'b0; tick(100); uart_rxd = 1'b1; tick(400);
    check_near("false_busy", busy_cnt, (period(3) - 1) / 2 + 1, 3);
    check("false_dlv", q.size(), 0);
    check("false_valid", int'(rx_valid), 0);

    // Second stop bit low, then break held for 5 bit times, then recovery.
    q.delete();
    send_frame(mk(6, 7, 0, 1, 'h3C, 0, 'h1, 0, 0, 0));
    busy_cnt = 0;
    tick(5 * period(6));
    check("brk_dlv", q.size(), 1);
    if (q.size() > 0) begin
      got = q.pop_front();
      check("brk_data", got & 'hFFFF, 'h3C);
      check("brk_ferr", (got >> 17) & 1, 1);
    end
    check("brk_busy", busy_cnt, 0);
    uart_rxd = 1'b1; tick(2 * period(6));
    check("brk_dlv2", q.size(), 0);
    run_frame(model(mk(6, 7, 0, 0, 'h5A, 0, 'h1, 0, 0, 0)), "brk_recover");

    // Overrun: two frames with the consumer stalled.
    rx_ready = 1'b0; q.delete();
    send_frame(mk(6, 7, 0, 0, 'h11, 0, 'h1, 0, 0, 0));
    uart_rxd = 1'b1; tick(3);
    ov0 = ov_cnt;
    send_frame(mk(6, 7, 0, 0, 'h22, 0, 'h1, 0, 0, 0));
    uart_rxd = 1'b1; tick(5);
    check("ovr_valid", int'(rx_valid), 1);
    check("ovr_data", int'(rx_data), 'h11);
    check("ovr_pulses", ov_cnt - ov0, 1);
    rx_ready = 1'b1; tick(1);
    check("ovr_drain", int'(rx_valid), 0);
    check("ovr_acc", q.size(), 1);
    if (q.size() > 0) check("ovr_accdata", q.pop_front() & 'hFFFF, 'h11);
    tick(10);

    // rx_en dropped mid-frame: current frame completes, next one is ignored.
    fork
      run_frame(model(mk(6, 7, 2, 0, 'hC4, 1, 'h1, 0, 0, 0)), "en_mid");
      begin tick(2 * period(6)); rx_en = 1'b0; end
    join
    busy_cnt = 0;
    send_frame(mk(6, 7, 0, 0, 'h99, 0, 'h1, 0, 0, 0));
    uart_rxd = 1'b1; tick(20);
    check("en_off_dlv", q.size(), 0);
    check("en_off_busy", busy_cnt, 0);
    rx_en = 1'b1; tick(5);

    // Randomized frames against the reference model.
    for (int k = 0; k < 12; k++) begin
      v.bps = ($urandom_range(0, 2) == 0) ? 5 : 6;
      v.dn = int'($urandom_range(0, 15));
      v.cm = int'($urandom_range(0, 3));
      v.sn = int'($urandom_range(0, 3));
      v.data = int'($urandom & 32'hFFFF);
      v.par = int'($urandom_range(0, 1));
      v.stops = int'(~($urandom & $urandom) & 32'hF);
      run_frame(model(v), $sformatf("rnd%0d", k));
    end

    // Reset in the middle of the data bits.
    q.delete();
    fork
      send_frame(mk(6, 7, 0, 0, 'hC3, 0, 'h1, 0, 0, 0));
      begin
        tick(3 * period(6));
        check("rstmid_busy_pre", int'(rx_busy), 1);
        rx_en = 1'b0;
        rst = 1'b1; #1;
        check("rstmid_busy", int'(rx_busy), 0);
        check("rstmid_valid", int'(rx_valid), 0);
        check("rstmid_data", int'(rx_data), 0);
        tick(2);
        rst = 1'b0;
      end
    join
    uart_rxd = 1'b1; tick(20);
    rx_en = 1'b1; tick(5);
    check("rstmid_dlv", q.size(), 0);
    check("rstmid_valid2", int'(rx_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_recv.md
Name: uart_recv

Overview:
UART receive stage on the far side of the serial link from the transmitter. It uses the same frame configuration as the transmitter (bps_mode, data_num, check_mode, stop_num) and samples the serial line at mid-bit. It rebuilds the data word, checks parity and stop bits, and hands the word to the bus-side logic through a one-entry valid/ready holding register.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz; used for the baud divisor.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
bps_mode  input  3  baud select: 0:9600, 1:19200, 2:38400, 3:115200, 4:230400, 5:460800, 6:921600, 7:9600
data_num  input  4  frame carries data_num+1 data bits (1..16)
check_mode  input  2  parity: 0 none, 1 odd, 2 even, 3 none
stop_num  input  2  frame carries stop_num+1 stop bits (1..4)
rx_en  input  1  receive enable
uart_rxd  input  1  serial line, asynchronous, idles high
rx_ready  input  1  consumer accepts rx_data
rx_data  output  16  received word, right-aligned, upper bits zero
rx_valid  output  1  rx_data/parity_err/frame_err are valid
parity_err  output  1  parity mismatch on the held word
frame_err  output  1  at least one stop bit sampled low on the held word
overrun_err  output  1  one-cycle pulse when a completed frame is dropped
rx_busy  output  1  frame reception in progress

Behaviour:
- Reset (rst high, async): state IDLE; synchroniser flops = 1; all counters = 0; all outputs = 0.
- uart_rxd passes through a 2-flop synchroniser to give rxd_s. A start edge is rxd_s going 1->0 (edge register also reset to 1).
- Baud divisor: bps_cnt = CLK_FREQ / rate_h / 100, integer division.
  - rate_h per mode: 96, 192, 384, 1152, 2304, 4608, 9216 (96 for mode 7).
  - Bit period P = bps_cnt+1 clocks. The bit counter runs 0..bps_cnt, then wraps.
  - Sample point: counter == bps_cnt>>1.
- Configuration is captured on the start edge. Changes to configuration inputs mid-frame are ignored.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Start edge while rx_en=1 -> START; bit counter cleared; rx_busy=1.
  - Edges while rx_en=0 are ignored.
- START: at the sample point:
  - rxd_s=1 -> false start, return to IDLE, rx_busy=0.
  - rxd_s=0 -> DATA.
- DATA:
  - One sample per P; data_num+1 samples taken, MSB first.
  - First sample lands in bit data_num of the shift word; the last sample lands in bit 0.
  - After the last sample -> PARITY if check_mode is 1 or 2, else STOP.
- PARITY: one sample.
  - Expected bit = ~^word for odd, ^word for even (XOR over the 16-bit right-aligned word).
  - Mismatch sets the local parity flag.
  - Then -> STOP.
- STOP:
  - stop_num+1 samples; any low sample sets the local frame flag.
  - After the last sample -> IDLE; rx_busy=0 on the same edge.
  - A new start edge can be detected from the next cycle onward.
- Delivery (cycle after the final stop sample):
  - If rx_valid=0 or rx_ready=1: load rx_data, parity_err, frame_err and set rx_valid=1.
  - Otherwise the new word is dropped, the held word is unchanged, and overrun_err pulses for 1 cycle.
- Handshake:
  - rx_valid stays high until a cycle with rx_ready=1.
  - rx_valid and rx_ready both high with no simultaneous delivery -> rx_valid=0 next cycle.
  - Simultaneous accept and delivery -> new word loaded, rx_valid stays 1, no overrun.
- rx_en deasserted mid-frame: the current frame completes and is delivered; no new frame starts.
- Line held low after a frame (break): frame_err is reported; no new frame until rxd_s has gone high and then low again.
- Reset mid-frame: immediate return to IDLE; partial word discarded; outputs cleared.

Test Plan:
- Basic frame: CLK_FREQ=50e6, bps_mode=3 (P=435), data_num=7, check_mode=0, stop_num=0; send start, 0xA5 MSB first, 1 stop bit -> rx_valid=1 with rx_data=0x00A5, errors 0; rx_busy high for ~9.5P.
- Parity: check_mode=2, data_num=7, data 0x07, parity bit driven 0 -> parity_err=1. Repeat with parity bit 1 -> parity_err=0. Then check_mode=1, parity bit 0 -> parity_err=0.
- False start: rx_en=1, 100-clock low glitch at bps_mode=3 -> rx_busy drops ~219 clocks after the edge; no rx_valid.
- Framing/break: stop_num=1, second stop bit low, then line held low 5P -> one rx_valid with the data intact and frame_err=1; no further frame until the line returns high and falls again.
- Overrun: rx_ready=0, two back-to-back frames 0x11 and 0x22 -> rx_data stays 0x0011, one overrun_err pulse. Then rx_ready=1 for one cycle -> rx_valid=0.
- Width/config/reset:
  - data_num=15 with 0xFFFF -> rx_data=0xFFFF.
  - Change bps_mode mid-frame -> word still correct.
  - Assert rst mid-DATA -> all outputs 0 and no rx_valid for that frame.
